// File: rtl/sarray_rd_arb.sv
// Read-channel arbiter: two requesters share one AR/R port. Grants are sticky
// round-robin bursts; an in-order owner-tag FIFO steers each R beat back.
module sarray_rd_arb #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256,
    parameter int OST_DEPTH  = 8,
    parameter int BURST_MAX  = 16,
    localparam int CW        = $clog2(OST_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_ar_valid_i,
    input  logic                  req1_ar_valid_i,
    output logic                  req0_ar_ready_o,
    output logic                  req1_ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_ar_addr_i,
    input  logic [ADDR_WIDTH-1:0] req1_ar_addr_i,
    output logic                  req0_r_valid_o,
    output logic                  req1_r_valid_o,
    input  logic                  req0_r_ready_i,
    input  logic                  req1_r_ready_i,
    output logic [DATA_WIDTH-1:0] req0_r_data_o,
    output logic [DATA_WIDTH-1:0] req1_r_data_o,
    output logic                  mem_ar_valid_o,
    input  logic                  mem_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr_o,
    input  logic                  mem_r_valid_i,
    output logic                  mem_r_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_r_data_i,
    output logic [CW-1:0]         ost_cnt_o,
    output logic                  idle_o,
    output logic                  err_o
);
    localparam int PW = $clog2(OST_DEPTH);
    localparam int RW = $clog2(BURST_MAX + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(BURST_MAX);
    localparam logic [CW-1:0] DEPTH   = CW'(OST_DEPTH);

    logic [1:0]           ar_vld;
    logic                 last_r;
    logic [RW-1:0]        run_cnt_r;
    logic [OST_DEPTH-1:0] tag_r;
    logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]        cnt_r;
    logic                 err_r;
    logic                 sel, sel_vld;
    logic                 full, empty, head;
    logic                 ar_hs, r_hs;

    assign ar_vld = {req1_ar_valid_i, req0_ar_valid_i};

    // Stay with the current owner until its run is exhausted, then yield if the other waits.
    always_comb begin
        sel     = last_r;
        sel_vld = 1'b0;
        if (ar_vld[last_r] && (run_cnt_r < RUN_MAX)) begin
            sel     = last_r;
            sel_vld = 1'b1;
        end else if (ar_vld[~last_r]) begin
            sel     = ~last_r;
            sel_vld = 1'b1;
        end else if (ar_vld[last_r]) begin
            sel     = last_r;
            sel_vld = 1'b1;
        end
    end

    assign full  = (cnt_r == DEPTH);
    assign empty = (cnt_r == '0);
    assign head  = tag_r[rd_ptr_r];

    assign mem_ar_valid_o  = sel_vld & ~full;
    assign mem_ar_addr_o   = sel ? req1_ar_addr_i : req0_ar_addr_i;
    assign req0_ar_ready_o = mem_ar_ready_i & ~full & sel_vld & ~sel & req0_ar_valid_i;
    assign req1_ar_ready_o = mem_ar_ready_i & ~full & sel_vld &  sel & req1_ar_valid_i;
    assign ar_hs           = mem_ar_valid_o & mem_ar_ready_i;

    assign req0_r_valid_o = mem_r_valid_i & ~empty & ~head;
    assign req1_r_valid_o = mem_r_valid_i & ~empty &  head;
    assign mem_r_ready_o  = ~empty & (head ? req1_r_ready_i : req0_r_ready_i);
    assign r_hs           = mem_r_valid_i & mem_r_ready_o;
    assign req0_r_data_o  = mem_r_data_i;
    assign req1_r_data_o  = mem_r_data_i;

    assign ost_cnt_o = cnt_r;
    assign idle_o    = empty & ~|ar_vld;
    assign err_o     = err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r    <= 1'b1;
            run_cnt_r <= RUN_MAX;
        end else if (ar_hs) begin
            if (sel == last_r) begin
                run_cnt_r <= (run_cnt_r == RUN_MAX) ? RW'(1) : run_cnt_r + RW'(1);
            end else begin
                last_r    <= sel;
                run_cnt_r <= RW'(1);
            end
        end
    end

    // Owner tags; a push into an empty FIFO reaches the head only on the next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            err_r    <= 1'b0;
        end else begin
            if (ar_hs) begin
                tag_r[wr_ptr_r] <= sel;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (r_hs) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({ar_hs, r_hs})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
            if (mem_r_valid_i && empty) err_r <= 1'b1;
        end
    end
endmodule

// File: doc/sarray_rd_arb.md
# sarray_rd_arb

Read-port arbiter sharing the single memory read channel (AR/R) between two requesters: requester 0 is the sarray tinst engine (TMMA B-operand and PRELOADA loads), and requester 1 is a second load client such as a C-preload or vector loader. It grants AR requests using round-robin with burst stickiness, so one requester's 64-beat sweep is not chopped finely. It records the owner of every accepted request in an in-order tag FIFO and steers each R beat back to that owner. The block sits between the sarray control logic and the memory interface and has no datapath storage beyond the tag FIFO.

## Interface
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 256, read data width (matches sarray load width)
- OST_DEPTH, 8, maximum outstanding accepted-but-unreturned reads; power of two, ≥2
- BURST_MAX, 16, maximum consecutive grants to one requester while the other is waiting; ≥1

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0_ar_valid_i / req1_ar_valid_i  in  1  read request valid
- req0_ar_ready_o / req1_ar_ready_o  out  1  request accepted this cycle
- req0_ar_addr_i / req1_ar_addr_i  in  ADDR_WIDTH  request address
- req0_r_valid_o / req1_r_valid_o  out  1  return beat valid for this requester
- req0_r_ready_i / req1_r_ready_i  in  1  requester accepts return beat
- req0_r_data_o / req1_r_data_o  out  DATA_WIDTH  return data; both carry mem_r_data_i
- mem_ar_valid_o  out  1  request to memory
- mem_ar_ready_i  in  1  memory accepts request
- mem_ar_addr_o  out  ADDR_WIDTH  selected address
- mem_r_valid_i  in  1  memory return valid
- mem_r_ready_o  out  1  return accepted
- mem_r_data_i  in  DATA_WIDTH  return data
- ost_cnt_o  out  $clog2(OST_DEPTH)+1  current outstanding count
- idle_o  out  1  high when ost_cnt_o==0 and neither requester is asserting AR valid
- err_o  out  1  sticky; set when mem_r_valid_i is high while the tag FIFO is empty

## Operation
- State:
  - last_r: requester of the most recent AR handshake; reset value 1.
  - run_cnt_r: consecutive grants to last_r; reset value BURST_MAX.
  - Tag FIFO: 1-bit entries, OST_DEPTH deep, with wr_ptr, rd_ptr and cnt registers, all reset to 0.
  - err_r: reset value 0.
- Select (combinational), evaluated in this order:
  1. If req[last_r] is valid and run_cnt_r < BURST_MAX, select last_r.
  2. Otherwise, if req[~last_r] is valid, select ~last_r.
  3. Otherwise, if req[last_r] is valid, select last_r.
  4. Otherwise, no selection.
- AR channel:
  - full = (cnt == OST_DEPTH).
  - mem_ar_valid_o = any selection & ~full.
  - mem_ar_addr_o = address of the selected requester.
  - reqX_ar_ready_o = mem_ar_ready_i & ~full & (sel==X) & reqX_ar_valid_i.
  - The non-selected requester's ready is always 0.
  - AR handshake = mem_ar_valid_o & mem_ar_ready_i.
- On an AR handshake:
  - Push sel into the FIFO at wr_ptr.
  - If sel==last_r: run_cnt_r = (run_cnt_r==BURST_MAX) ? 1 : run_cnt_r+1.
  - Else: last_r = sel and run_cnt_r = 1.
- R channel:
  - empty = (cnt==0); head = fifo[rd_ptr].
  - reqX_r_valid_o = mem_r_valid_i & ~empty & (head==X).
  - mem_r_ready_o = ~empty & req[head]_r_ready_i.
  - R handshake pops the FIFO.
  - Returns are strictly in order; memory must return in AR order.
- Count and pointers:
  - Simultaneous push and pop leaves cnt unchanged; both pointers advance.
  - Pointers wrap modulo OST_DEPTH.
- Full: no AR accepted, even if a pop happens in the same cycle. Full is sampled from the registered cnt; there is no bypass.
- Empty:
  - mem_r_ready_o = 0.
  - A beat arriving with mem_r_valid_i high is not consumed, and err_r is set. err_r is cleared only by rst.
- Reset mid-operation: all state returns to reset values, and in-flight returns are forgotten. The memory side must be reset together with this block.

## Timing
- AR path and R path are both combinational pass-through, 0-cycle latency, with no registered data stage.
- No valid output depends combinationally on a ready input.
- ost_cnt_o and idle_o reflect registered state plus current AR valids.
- A push is visible at the head on the cycle after the push when the FIFO was empty; a same-cycle push-to-pop bypass is not allowed.
- Reset values:
  - All *_valid_o and *_ready_o are 0; they are driven combinationally from empty/full state.
  - ost_cnt_o = 0, idle_o = 1, err_o = 0.
- Arbitration decision for cycle N uses last_r and run_cnt_r as registered at the end of cycle N-1.

## Test plan
- Only req0 valid for 20 cycles with mem_ar_ready_i=1 and memory returning each beat 2 cycles later → 20 AR handshakes, all returns on req0_r_valid_o, ost_cnt_o peaks at 2, idle_o=1 after the last return.
- Both requesters valid continuously with BURST_MAX=16 → grant pattern is 16×req0, then 16×req1, then 16×req0; the first grant after reset goes to req0.
- Hold mem_r_valid_i=0 and issue 10 requests with OST_DEPTH=8 → exactly 8 accepted, mem_ar_valid_o=0 while full. Then return 1 beat → the 9th request is accepted on the following cycle, not the same cycle.
- Interleave 3 grants as req0, req1, req0 → returns route to req0, req1, req0 in that order. Hold req1_r_ready_i=0 on beat 2 → mem_r_ready_o=0 and beat 3 is stalled.
- Assert mem_r_valid_i with nothing outstanding → mem_r_ready_o=0, err_o goes to 1 the next cycle and stays at 1.
- Assert rst with 5 reads outstanding → next cycle ost_cnt_o=0, all valids and readies are 0, and the first grant after release goes to req0.
